// File: rtl/tia_player_graphics_scan_engine.sv
// ============================================================================
// Module   : tia_player_graphics_scan_engine
// Brief    : Player graphics new/old registers with vertical delay, serialised
//            with per-bit stretch and reflection, plus the missile reset strobe.
//            Optional macro TIA_PLAYER_GRAPHICS_SCAN_ENGINE_LATCH_EN holds
//            reflect/scale/vert_delay in shadow registers for the whole scan.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tia_player_graphics_scan_engine #(
    parameter int GFX_WIDTH    = 8,
    parameter int SCALE_BITS   = 2,
    parameter int MRESET_INDEX = 3
) (
    input  logic                         clock,
    input  logic                         reset_bar,
    input  logic                         count_enable,
    input  logic                         start,
    input  logic [GFX_WIDTH-1:0]         gfx_in,
    input  logic                         gfx_load,
    input  logic                         copy_old,
    input  logic                         vert_delay,
    input  logic                         reflect,
    input  logic [SCALE_BITS-1:0]        scale,
    input  logic                         missile_reset_en,
    output logic                         busy,
    output logic [$clog2(GFX_WIDTH)-1:0] scan_index,
    output logic                         missile_to_player_reset,
    output logic                         p
);

    localparam int c_idx_w     = $clog2(GFX_WIDTH);
    localparam int c_stretch_w = (1 << SCALE_BITS) - 1;

    localparam logic [c_idx_w-1:0]     c_last_idx    = c_idx_w'(GFX_WIDTH - 1);
    localparam logic [c_idx_w-1:0]     c_mreset_idx  = c_idx_w'(MRESET_INDEX);
    localparam logic [c_idx_w-1:0]     c_idx_one     = c_idx_w'(1);
    localparam logic [c_stretch_w-1:0] c_stretch_one = c_stretch_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_idx_w-1:0]     r_scan_index;
    logic [c_stretch_w-1:0] r_stretch;
    logic                   r_p;
    logic [GFX_WIDTH-1:0]   r_gfx_new;
    logic [GFX_WIDTH-1:0]   r_gfx_old;

    logic                   w_reflect;
    logic                   w_vert_delay;
    logic [SCALE_BITS-1:0]  w_scale;
    logic [c_stretch_w:0]   w_factor;
    logic [c_stretch_w-1:0] w_mask;
    logic                   w_stretch_done;
    logic [c_idx_w-1:0]     w_sel;
    logic [GFX_WIDTH-1:0]   w_src;
    logic                   w_busy;
    logic                   w_advance;

`ifdef TIA_PLAYER_GRAPHICS_SCAN_ENGINE_LATCH_EN
    logic                  r_reflect_q;
    logic                  r_vert_delay_q;
    logic [SCALE_BITS-1:0] r_scale_q;

    always_ff @(posedge clock or negedge reset_bar) begin
        if (!reset_bar) begin
            r_reflect_q    <= 1'b0;
            r_vert_delay_q <= 1'b0;
            r_scale_q      <= '0;
        end else if (start && count_enable) begin
            r_reflect_q    <= reflect;
            r_vert_delay_q <= vert_delay;
            r_scale_q      <= scale;
        end
    end

    assign w_reflect    = r_reflect_q;
    assign w_vert_delay = r_vert_delay_q;
    assign w_scale      = r_scale_q;
`else
    assign w_reflect    = reflect;
    assign w_vert_delay = vert_delay;
    assign w_scale      = scale;
`endif

    // Terminal stretch count is (1<<scale)-1; plain equality on the full-width
    // counter lets an overshoot after a mid-scan scale drop wrap instead of hang.
    assign w_factor       = (c_stretch_w + 1)'(1) << w_scale;
    assign w_mask         = w_factor[c_stretch_w-1:0] - c_stretch_one;
    assign w_stretch_done = (r_stretch == w_mask);

    assign w_busy    = (r_state == ST_SCAN);
    assign w_advance = count_enable && !start && w_busy;
    assign w_sel     = w_reflect ? r_scan_index : (c_last_idx - r_scan_index);
    assign w_src     = w_vert_delay ? r_gfx_old : r_gfx_new;

    // gfx_old captures the pre-edge gfx_new, so a same-cycle load and copy
    // shifts the pair exactly like back-to-back GRP writes.
    always_ff @(posedge clock or negedge reset_bar) begin
        if (!reset_bar) begin
            r_gfx_new <= '0;
            r_gfx_old <= '0;
        end else begin
            if (copy_old) begin
                r_gfx_old <= r_gfx_new;
            end
            if (gfx_load) begin
                r_gfx_new <= gfx_in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_bar) begin
        if (!reset_bar) begin
            r_state      <= ST_IDLE;
            r_scan_index <= '0;
            r_stretch    <= '0;
            r_p          <= 1'b0;
        end else begin
            r_p <= w_busy & w_src[w_sel];
            if (count_enable && start) begin
                r_state      <= ST_SCAN;
                r_scan_index <= '0;
                r_stretch    <= '0;
            end else if (w_advance) begin
                if (w_stretch_done) begin
                    r_stretch <= '0;
                    if (r_scan_index == c_last_idx) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_scan_index <= r_scan_index + c_idx_one;
                    end
                end else begin
                    r_stretch <= r_stretch + c_stretch_one;
                end
            end
        end
    end

    assign busy       = w_busy;
    assign scan_index = r_scan_index;
    assign p          = r_p;

    assign missile_to_player_reset = w_busy && missile_reset_en && count_enable &&
                                     (r_scan_index == c_mreset_idx) &&
                                     (r_stretch == '0);

endmodule

`default_nettype wire

// File: tb/tb_tia_player_graphics_scan_engine.sv
// ============================================================================
// Module   : tb_tia_player_graphics_scan_engine
// Brief    : Scoreboard bench for the player graphics scan engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tia_player_graphics_scan_engine;

    localparam int W  = 8;
    localparam int SB = 2;
    localparam int MR = 3;

    logic           clock = 1'b0;
    logic           reset_bar;
    logic           count_enable;
    logic           start;
    logic [W-1:0]   gfx_in;
    logic           gfx_load;
    logic           copy_old;
    logic           vert_delay;
    logic           reflect;
    logic [SB-1:0]  scale;
    logic           missile_reset_en;
    logic           busy;
    logic [2:0]     scan_index;
    logic           missile_to_player_reset;
    logic           p;

    always #5 clock = ~clock;

    tia_player_graphics_scan_engine #(
        .GFX_WIDTH    (W),
        .SCALE_BITS   (SB),
        .MRESET_INDEX (MR)
    ) dut (
        .clock                   (clock),
        .reset_bar               (reset_bar),
        .count_enable            (count_enable),
        .start                   (start),
        .gfx_in                  (gfx_in),
        .gfx_load                (gfx_load),
        .copy_old                (copy_old),
        .vert_delay              (vert_delay),
        .reflect                 (reflect),
        .scale                   (scale),
        .missile_reset_en        (missile_reset_en),
        .busy                    (busy),
        .scan_index              (scan_index),
        .missile_to_player_reset (missile_to_player_reset),
        .p                       (p)
    );

    typedef struct packed {
        logic       busy;
        logic [2:0] idx;
        logic       mr;
        logic       p;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc_no      = 0;

    // Reference model: a scan is a tick count t since start; the pixel index
    // is t / 2^scale and the scan ends after W * 2^scale counted ticks.
    bit         m_active = 0;
    int         m_t      = 0;
    int         m_scale  = 0;
    bit         m_p      = 0;
    logic [7:0] m_new    = '0;
    logic [7:0] m_old    = '0;

    bit         cfg_rb = 0;
    bit         cfg_ce = 1;
    bit         cfg_vd = 0;
    bit         cfg_rf = 0;
    bit         cfg_en = 0;
    logic [1:0] cfg_sc = '0;

    task automatic cycle(input bit st, input bit ld, input bit cp, input logic [7:0] din);
        exp_t       e;
        int         idx;
        int         str;
        int         sel;
        logic [7:0] src;
        @(posedge clock);
        #1;
        reset_bar        = cfg_rb;
        count_enable     = cfg_ce;
        vert_delay       = cfg_vd;
        reflect          = cfg_rf;
        scale            = cfg_sc;
        missile_reset_en = cfg_en;
        start            = st;
        gfx_load         = ld;
        copy_old         = cp;
        gfx_in           = din;
        cyc_no++;
        if (!cfg_rb) begin
            m_active = 0; m_t = 0; m_scale = 0; m_p = 0; m_new = '0; m_old = '0;
        end
        idx    = m_t / (1 << m_scale);
        str    = m_t % (1 << m_scale);
        e.busy = m_active;
        e.idx  = 3'(idx);
        e.mr   = m_active && cfg_en && cfg_ce && (idx == MR) && (str == 0);
        e.p    = m_p;
        exp_q.push_back(e);
        if (cfg_rb) begin
            src = cfg_vd ? m_old : m_new;
            sel = cfg_rf ? idx : (W - 1 - idx);
            m_p = m_active && src[sel];
            if (cp) m_old = m_new;
            if (ld) m_new = din;
            if (cfg_ce) begin
                if (st) begin
                    m_active = 1; m_t = 0; m_scale = int'(cfg_sc);
                end else if (m_active) begin
                    if (m_t == (W << m_scale) - 1) m_active = 0;
                    else m_t++;
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (busy !== e.busy || p !== e.p || missile_to_player_reset !== e.mr ||
                (e.busy && scan_index !== e.idx)) begin
                miscompares++;
                $display("FAIL scan_out cycle %0d: busy/idx/mreset/p got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         cyc_no, busy, scan_index, missile_to_player_reset, p,
                         e.busy, e.idx, e.mr, e.p);
            end
        end
    end

    initial begin
        reset_bar = 0; count_enable = 0; start = 0; gfx_in = '0; gfx_load = 0;
        copy_old = 0; vert_delay = 0; reflect = 0; scale = '0; missile_reset_en = 0;

        cfg_rb = 0;
        idle_cycles(3);
        cfg_rb = 1;
        idle_cycles(2);

        // A5 MSB first, unstretched
        cycle(0, 1, 0, 8'hA5);
        cycle(1, 0, 0, 8'h00);
        idle_cycles(11);

        // LSB first, each bit doubled
        cfg_rf = 1; cfg_sc = 2'd1;
        cycle(1, 0, 0, 8'h00);
        idle_cycles(19);
        cfg_rf = 0; cfg_sc = 2'd0;

        // Vertical delay ordering
        cycle(0, 1, 0, 8'hFF);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 1, 0, 8'h00);
        cfg_vd = 1;
        cycle(1, 0, 0, 8'h00);
        idle_cycles(10);
        cfg_vd = 0;
        cycle(1, 0, 0, 8'h00);
        idle_cycles(10);

        // Missile reset strobe with and without enable, scale 4x
        cycle(0, 1, 0, 8'h3C);
        cfg_en = 1; cfg_sc = 2'd2;
        cycle(1, 0, 0, 8'h00);
        idle_cycles(35);
        cfg_en = 0;
        cycle(1, 0, 0, 8'h00);
        idle_cycles(35);
        cfg_sc = 2'd0;

        // Alternating count_enable
        cfg_en = 1;
        cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            cfg_ce = (i % 2) == 1;
            cycle(0, 0, 0, 8'h00);
        end
        cfg_ce = 1;
        idle_cycles(3);

        // Restart at scan_index 5
        cycle(0, 1, 0, 8'h96);
        cycle(1, 0, 0, 8'h00);
        idle_cycles(5);
        cycle(1, 0, 0, 8'h00);
        idle_cycles(11);

        // Reset mid-scan, then confirm both registers were cleared
        cycle(1, 0, 0, 8'h00);
        idle_cycles(4);
        cfg_rb = 0;
        cycle(0, 0, 0, 8'h00);
        cfg_rb = 1;
        cfg_vd = 1;
        cycle(1, 0, 0, 8'h00);
        idle_cycles(10);
        cfg_vd = 0;
        cycle(1, 0, 0, 8'h00);
        idle_cycles(10);

        // Randomized traffic; config changes only between scans
        for (int i = 0; i < 3000; i++) begin
            if (!m_active) begin
                cfg_sc = 2'($urandom_range(0, 3));
                cfg_rf = ($urandom % 2) == 1;
                cfg_vd = ($urandom % 2) == 1;
                cfg_en = ($urandom % 2) == 1;
            end
            cfg_ce = ($urandom % 4) != 0;
            cfg_rb = ($urandom % 400) != 0;
            cycle(($urandom % 30) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
                  8'($urandom));
        end
        cfg_rb = 1;
        idle_cycles(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
